// File: rtl/imem_loader.sv
// imem_loader: copies a program from a source FIFO into instruction memory,
// one 32-bit word every two cycles, then releases the processor.
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   start         - load request (honoured only in IDLE/DONE/ERROR)
//   prog_len      - number of words to load, captured on an accepted start
//   fifo_empty    - source FIFO empty
//   fifo_rd_en    - source FIFO pop strobe
//   fifo_rd_data  - FIFO read data, valid the cycle after fifo_rd_en
//   imem_wr_addr  - byte address for the memory write port
//   imem_data_in  - instruction for the memory write port
//   imem_w_en     - memory write enable
//   busy          - load in progress
//   done          - load finished (held until the next accepted start)
//   cpu_run       - processor release, high only in DONE
//   len_clamped   - prog_len exceeded the memory size and was clamped
//   timeout       - FIFO starvation abort flag
//
// Build option: define IMEM_LOADER_TIMEOUT_EN to abort into ERROR after
// TIMEOUT_CYCLES consecutive starved READ cycles. Without it READ waits
// indefinitely and timeout is tied low.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_DEPTH      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] prog_len,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [DATA_WIDTH-1:0] imem_data_in,
    output logic                  imem_w_en,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_run,
    output logic                  len_clamped,
    output logic                  timeout
);

    localparam int unsigned LEN_W = ADDR_WIDTH - 1;
    localparam int unsigned WORDS = MEM_DEPTH / 4;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      word_cnt_q;
    logic [LEN_W-1:0]      len_eff;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  clamp;
    logic                  accept;
    logic                  pop;
    logic                  last;
    logic                  starve;

    // Length clamp keeps the final address at MEM_DEPTH-4, so addr never wraps.
    assign clamp   = prog_len > LEN_W'(WORDS);
    assign len_eff = clamp ? LEN_W'(WORDS) : prog_len;
    assign last    = (word_cnt_q + LEN_W'(1)) == len_q;

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCNT_W-1:0] tcnt_q;

    // Final starved cycle: this READ cycle makes TIMEOUT_CYCLES in a row.
    assign starve = (state_q == READ) && fifo_empty
                    && (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

    // Consecutive starved-READ counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q  <= '0;
            timeout <= 1'b0;
        end else if (accept) begin
            tcnt_q  <= '0;
            timeout <= 1'b0;
        end else if (pop) begin
            tcnt_q  <= '0;
        end else if ((state_q == READ) && fifo_empty) begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
            if (starve) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    assign starve  = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (len_eff == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = WRITE;
                end else if (starve) begin
                    state_d = ERROR;
                end
            end
            WRITE: begin
                state_d = last ? DONE : READ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load bookkeeping and held write-port values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            word_cnt_q  <= '0;
            addr_q      <= '0;
            wr_addr_q   <= '0;
            data_q      <= '0;
            len_clamped <= 1'b0;
        end else begin
            if (accept) begin
                len_q       <= len_eff;
                word_cnt_q  <= '0;
                addr_q      <= '0;
                len_clamped <= clamp;
            end
            // Address is presented from the pop edge so it is stable in WRITE
            // and keeps its value until the next word is popped.
            if (pop) begin
                wr_addr_q <= addr_q;
            end
            if (state_q == WRITE) begin
                data_q     <= fifo_rd_data;
                word_cnt_q <= word_cnt_q + LEN_W'(1);
                if (!last) begin
                    addr_q <= addr_q + ADDR_WIDTH'(4);
                end
            end
        end
    end

    // FIFO read data only arrives in WRITE, so the data port passes it through
    // then and shows the captured copy otherwise.
    assign fifo_rd_en   = pop;
    assign imem_w_en    = (state_q == WRITE);
    assign imem_wr_addr = wr_addr_q;
    assign imem_data_in = (state_q == WRITE) ? fifo_rd_data : data_q;
    assign busy         = (state_q == READ) || (state_q == WRITE);
    assign done         = (state_q == DONE);
    assign cpu_run      = (state_q == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: FIFO model, write scoreboard and invariant monitor.
module tb_imem_loader;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned TOUT  = 16;
    localparam int unsigned LW    = AW - 1;
    localparam int          WORDS = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] prog_len;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic [AW-1:0] imem_wr_addr;
    logic [DW-1:0] imem_data_in;
    logic          imem_w_en;
    logic          busy;
    logic          done;
    logic          cpu_run;
    logic          len_clamped;
    logic          timeout;

    logic [AW+DW+6:0] outs;
    assign outs = {fifo_rd_en, imem_wr_addr, imem_data_in, imem_w_en,
                   busy, done, cpu_run, len_clamped, timeout};

    imem_loader #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .MEM_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_len    (prog_len),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .imem_wr_addr(imem_wr_addr),
        .imem_data_in(imem_data_in),
        .imem_w_en   (imem_w_en),
        .busy        (busy),
        .done        (done),
        .cpu_run     (cpu_run),
        .len_clamped (len_clamped),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]    fq[$];
    logic [AW+DW-1:0] wr_log[$];
    int               rd_cnt    = 0;
    int               underflow = 0;
    bit               rand_stall = 1'b0;
    bit               stall      = 1'b0;

    int v_both = 0, v_align = 0, v_busydone = 0, v_cpu = 0, v_popempty = 0, v_hold = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO empty flag changes just after the rising edge, with optional random starvation.
    always @(posedge clk) begin
        #1;
        stall      = rand_stall && ($urandom_range(0, 3) == 0);
        fifo_empty = (fq.size() == 0) || stall;
    end

    // Mid-cycle monitor: invariants, write log, FIFO pop (data valid next cycle).
    always @(negedge clk) begin
        if (rst) begin
            prev_addr = '0;
            prev_data = '0;
        end else begin
            if (fifo_rd_en && imem_w_en) v_both++;
            if (imem_wr_addr[1:0] != 2'b00) v_align++;
            if (busy && done) v_busydone++;
            if (cpu_run != done) v_cpu++;
            if (fifo_rd_en && fifo_empty) v_popempty++;
            if (!imem_w_en && (imem_wr_addr != prev_addr || imem_data_in != prev_data)) v_hold++;
            if (imem_w_en) wr_log.push_back({imem_wr_addr, imem_data_in});
            prev_addr = imem_wr_addr;
            prev_data = imem_data_in;
            if (fifo_rd_en) begin
                rd_cnt++;
                if (fq.size() > 0) fifo_rd_data = fq.pop_front();
                else underflow++;
            end
        end
    end

    // Expected image: word i at byte address 4*i, in FIFO order.
    task automatic check_writes(input string tag, input logic [DW-1:0] exp[$]);
        int bad = 0;
        logic [AW+DW-1:0] e;
        check({tag, "_count"}, 64'(wr_log.size()), 64'(exp.size()));
        for (int i = 0; i < wr_log.size(); i++) begin
            e = wr_log[i];
            if (i >= exp.size()) bad++;
            else if (e[AW+DW-1:DW] != AW'(4 * i) || e[DW-1:0] != exp[i]) bad++;
        end
        check({tag, "_contents"}, 64'(bad), 64'(0));
    endtask

    // One full load: random program, optional starvation and ignored start pulses.
    task automatic run_load(input string tag, input int plen, input bit rstall, input bit noise,
                            input int exp_words, input bit exp_clamp);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] w;
        int cyc;
        exp_q = {};
        wr_log.delete();
        rd_cnt = 0;
        for (int i = 0; i < exp_words; i++) begin
            w = $urandom;
            fq.push_back(w);
            exp_q.push_back(w);
        end
        rand_stall = rstall;
        @(negedge clk);
        prog_len = LW'(plen);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 8 * exp_words + 50) begin
            if (noise) start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        rand_stall = 1'b0;
        check({tag, "_done"}, 64'(done), 64'(1));
        if (!rstall) check({tag, "_latency"}, 64'(cyc), 64'(2 * exp_words + 1));
        check({tag, "_clamped"}, 64'(len_clamped), 64'(exp_clamp));
        check({tag, "_cpu_run"}, 64'(cpu_run), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_timeout"}, 64'(timeout), 64'(0));
        check({tag, "_pops"}, 64'(rd_cnt), 64'(exp_words));
        check_writes(tag, exp_q);
        fq.delete();
    endtask

    typedef struct {
        int plen;
        bit rstall;
        bit noise;
        int exp_words;
        bit exp_clamp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [DW-1:0] fixed_q[$];
        logic [DW-1:0] w;
        int cyc;
        int cnt;
        int plen;
        int n;

        vecs[0] = '{plen: 4,   rstall: 0, noise: 0, exp_words: 4,   exp_clamp: 0};
        vecs[1] = '{plen: 0,   rstall: 0, noise: 0, exp_words: 0,   exp_clamp: 0};
        vecs[2] = '{plen: 1,   rstall: 0, noise: 1, exp_words: 1,   exp_clamp: 0};
        vecs[3] = '{plen: 256, rstall: 0, noise: 0, exp_words: 256, exp_clamp: 0};
        vecs[4] = '{plen: 257, rstall: 0, noise: 0, exp_words: 256, exp_clamp: 1};
        vecs[5] = '{plen: 300, rstall: 0, noise: 1, exp_words: 256, exp_clamp: 1};
        vecs[6] = '{plen: 511, rstall: 1, noise: 1, exp_words: 256, exp_clamp: 1};
        vecs[7] = '{plen: 3,   rstall: 1, noise: 1, exp_words: 3,   exp_clamp: 0};
        vecs[8] = '{plen: 17,  rstall: 1, noise: 0, exp_words: 17,  exp_clamp: 0};

        rst = 1'b1;
        start = 1'b0;
        prog_len = '0;
        fifo_empty = 1'b1;
        fifo_rd_data = '0;

        // Reset values, then idle after release with no start.
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'(outs), 64'(0));
        rst = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || cpu_run || done || fifo_rd_en || imem_w_en) cnt++;
        end
        check("idle_after_reset", 64'(cnt), 64'(0));

        // Four-instruction program, cycle-exact from the accepting edge.
        fixed_q = '{32'h0000_0013, 32'h0010_0093, 32'h0020_8133, 32'h0000_006F};
        foreach (fixed_q[i]) fq.push_back(fixed_q[i]);
        wr_log.delete();
        prog_len = LW'(4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("prog4_done_c%0d", c), 64'(done), 64'(c == 9));
            check($sformatf("prog4_wen_c%0d", c), 64'(imem_w_en), 64'((c % 2 == 0) && c <= 8));
            if (c < 9) @(negedge clk);
        end
        check("prog4_cpu_run", 64'(cpu_run), 64'(1));
        @(negedge clk);
        check_writes("prog4", fixed_q);

        // Table of load lengths and stress modes.
        foreach (vecs[i]) begin
            run_load($sformatf("vec%0d", i), vecs[i].plen, vecs[i].rstall, vecs[i].noise,
                     vecs[i].exp_words, vecs[i].exp_clamp);
        end

        // Random lengths against the clamp rule.
        for (int r = 0; r < 5; r++) begin
            plen = $urandom_range(1, 320);
            n = (plen > WORDS) ? WORDS : plen;
            run_load($sformatf("rnd%0d", r), plen, (r % 2) == 1, 1'b1, n, plen > WORDS);
        end

        // Starved FIFO for five cycles before word 2, with start pulses in the gap.
        fixed_q = {};
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            fixed_q.push_back(w);
        end
        wr_log.delete();
        rd_cnt = 0;
        fq.push_back(fixed_q[0]);
        @(negedge clk);
        prog_len = LW'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 7) begin
            @(negedge clk);
            cyc++;
            start = 1'b1;
        end
        start = 1'b0;
        check("starve_pops_in_gap", 64'(rd_cnt), 64'(1));
        check("starve_busy_in_gap", 64'(busy), 64'(1));
        fq.push_back(fixed_q[1]);
        fq.push_back(fixed_q[2]);
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("starve_done_cycle", 64'(cyc), 64'(12));
        check_writes("starve", fixed_q);

        // Asynchronous reset during the write of word 2 of 8, then reload.
        for (int i = 0; i < 8; i++) fq.push_back($urandom);
        @(negedge clk);
        prog_len = LW'(8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(imem_w_en && imem_wr_addr == AW'(4)) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("midload_reached_word2", 64'(imem_w_en && imem_wr_addr == AW'(4)), 64'(1));
        rst = 1'b1;
        #1;
        check("midload_reset_outputs", 64'(outs), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        fq.delete();
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || cpu_run || done || fifo_rd_en || imem_w_en) cnt++;
        end
        check("midload_no_autostart", 64'(cnt), 64'(0));
        run_load("reload2", 2, 1'b0, 1'b0, 2, 1'b0);

        // FIFO dries up after the first of two words.
        wr_log.delete();
        fq.push_back($urandom);
        @(negedge clk);
        prog_len = LW'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef IMEM_LOADER_TIMEOUT_EN
        cyc = 1;
        cnt = 0;
        while (!timeout && cyc < 200) begin
            if (busy && fifo_empty && !imem_w_en) cnt++;
            @(negedge clk);
            cyc++;
        end
        check("tout_flag", 64'(timeout), 64'(1));
        check("tout_empty_cycles", 64'(cnt), 64'(TOUT));
        check("tout_cpu_run", 64'(cpu_run), 64'(0));
        check("tout_busy", 64'(busy), 64'(0));
        check("tout_done", 64'(done), 64'(0));
        check("tout_writes", 64'(wr_log.size()), 64'(1));
        run_load("after_tout", 3, 1'b0, 1'b0, 3, 1'b0);
`else
        repeat (200) @(negedge clk);
        check("hang_busy", 64'(busy), 64'(1));
        check("hang_done", 64'(done), 64'(0));
        check("hang_timeout", 64'(timeout), 64'(0));
        check("hang_writes", 64'(wr_log.size()), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif

        check("inv_rd_and_wr", 64'(v_both), 64'(0));
        check("inv_addr_align", 64'(v_align), 64'(0));
        check("inv_busy_and_done", 64'(v_busydone), 64'(0));
        check("inv_cpu_run_eq_done", 64'(v_cpu), 64'(0));
        check("inv_pop_while_empty", 64'(v_popempty), 64'(0));
        check("inv_hold_when_idle", 64'(v_hold), 64'(0));
        check("inv_fifo_underflow", 64'(underflow), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
